lsu_subword_ctrl: RTL and testbench

Load/store controller sitting directly upstream of the word-only data memory. Accepts byte/half/word load and store requests from the execute stage using byte addresses and RV32I funct3 encoding. Converts them into word-indexed memory accesses, performing read-modify-write for sub-word stores and lane extraction with sign/zero extension for loads. Flags misaligned, out-of-range or illegal requests without touching memory.

---
 rtl/lsu_subword_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lsu_subword_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword_ctrl.sv
// Sub-word load/store controller in front of a word-only data memory.
// Byte/half/word requests (RV32I funct3) become word-indexed accesses:
// read-modify-write for sub-word stores, lane extraction plus sign/zero
// extension for loads. Bad requests are rejected without touching memory.
module lsu_subword_ctrl #(
  parameter int n   = 32,
  parameter int A_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [2:0]     req_funct3,
  input  logic [n-1:0]   req_addr,
  input  logic [n-1:0]   req_wdata,
  output logic           rsp_valid,
  output logic [n-1:0]   rsp_rdata,
  output logic           rsp_err,
  output logic [A_W-1:0] mem_addr,
  output logic           mem_we,
  output logic [n-1:0]   mem_wdata,
  input  logic [n-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state, state_nxt;

  // Only the lane offset and low store bytes are needed after accept; the
  // word index lives directly in mem_addr and full-word store data goes
  // straight into mem_wdata.
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [15:0] wdata_q;

  logic         accept;
  logic         req_err;
  logic [7:0]   byte_v;
  logic [15:0]  half_v;
  logic [n-1:0] load_val;
  logic [n-1:0] merge_val;

  // Reject illegal encodings, misalignment and out-of-range addresses
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = (req_addr[1:0] != 2'b00);
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (req_addr[n-1:A_W+2] != '0) req_err = 1'b1;
  end

  // Lane extraction with sign/zero extension for loads
  always_comb begin
    byte_v = '0;
    case (lane_q)
      2'd0: byte_v = mem_rdata[7:0];
      2'd1: byte_v = mem_rdata[15:8];
      2'd2: byte_v = mem_rdata[23:16];
      2'd3: byte_v = mem_rdata[31:24];
      default: byte_v = '0;
    endcase
    half_v = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{(n-8){byte_v[7]}}, byte_v};
      3'b100:  load_val = {{(n-8){1'b0}}, byte_v};
      3'b001:  load_val = {{(n-16){half_v[15]}}, half_v};
      3'b101:  load_val = {{(n-16){1'b0}}, half_v};
      default: load_val = mem_rdata;
    endcase
  end

  // Merge store bytes into the old word for sub-word stores
  always_comb begin
    merge_val = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        2'd3: merge_val[31:24] = wdata_q[7:0];
        default: merge_val = mem_rdata;
      endcase
    end else if (lane_q[1]) begin
      merge_val[31:16] = wdata_q;
    end else begin
      merge_val[15:0] = wdata_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/strobe outputs, all gated by reset
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        accept    = req_valid & rst_n;
        if (accept) begin
          if (req_err)                              state_nxt = RESP;
          else if (req_we && req_funct3 == 3'b010)  state_nxt = WR;
          else                                      state_nxt = RD;
        end
      end
      RD:   state_nxt = we_q ? WR : RESP;
      WR: begin
        mem_we    = rst_n;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = rst_n;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, memory address/data and response registers; response
  // fields change only on edges that enter RESP so they hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q    <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lane_q   <= req_addr[1:0];
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata[15:0];
            if (req_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= req_addr[A_W+1:2];
              if (req_we && req_funct3 == 3'b010) mem_wdata <= req_wdata;
            end
          end
        end
        RD: begin
          if (we_q) begin
            mem_wdata <= merge_val;
          end else begin
            rsp_rdata <= load_val;
            rsp_err   <= 1'b0;
          end
        end
        WR: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Bench for lsu_subword_ctrl: word memory model, directed requests with
// hand-computed results pushed to a scoreboard, monitor compares responses.
module tb_lsu_subword_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          tag;
  } exp_t;

  exp_t exp_q[$];

  lsu_subword_ctrl #(.n(32), .A_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
      errors++;
    end
  endtask

  // Monitor: count write strobes and score every response
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h expected no response", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("rdata_%0d", e.tag), rsp_rdata, e.rdata);
        chk($sformatf("err_%0d", e.tag), {31'b0, rsp_err}, {31'b0, e.err});
        chk($sformatf("latency_%0d", e.tag), cyc - e.acc + 1, e.lat);
      end
    end
  end

  // Drive a request and return the cycle number following its accept edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                       input int lat, input int tag, input logic push, output int acc);
    int w;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    acc = cyc + 1;
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_%0d: got req_ready=0 expected 1", tag);
    end else if (push) begin
      e.rdata = erd; e.err = eerr; e.acc = acc; e.lat = lat; e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain(input int tag);
    int w;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout_%0d: got %0d pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, wc;
    for (int unsigned i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 32'h8765_4321;
    mem[2] = 32'hAABB_CCDD;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Loads from word 5
    wc = we_cnt;
    issue(1'b0, 3'b010, 32'h14, '0, 32'h8765_4321, 1'b0, 2, 1, 1'b1, a); drain(1);
    issue(1'b0, 3'b000, 32'h17, '0, 32'hFFFF_FF87, 1'b0, 2, 2, 1'b1, a); drain(2);
    issue(1'b0, 3'b100, 32'h17, '0, 32'h0000_0087, 1'b0, 2, 3, 1'b1, a); drain(3);
    issue(1'b0, 3'b001, 32'h16, '0, 32'hFFFF_8765, 1'b0, 2, 4, 1'b1, a); drain(4);
    issue(1'b0, 3'b101, 32'h14, '0, 32'h0000_4321, 1'b0, 2, 5, 1'b1, a); drain(5);
    issue(1'b0, 3'b000, 32'h14, '0, 32'h0000_0021, 1'b0, 2, 6, 1'b1, a); drain(6);
    chk("loads_no_write", we_cnt - wc, 0);

    // Sub-word store: read-modify-write
    wc = we_cnt;
    issue(1'b1, 3'b000, 32'h09, 32'h1234_5611, 32'h0, 1'b0, 3, 7, 1'b1, a); drain(7);
    chk("sb_we_pulses", we_cnt - wc, 1);
    chk("sb_mem2", mem[2], 32'hAABB_11DD);

    // Rejected requests
    wc = we_cnt;
    issue(1'b1, 3'b010, 32'h02,   32'hFFFF_FFFF, 32'h0, 1'b1, 1, 8, 1'b1, a); drain(8);
    issue(1'b0, 3'b001, 32'h03,   '0,            32'h0, 1'b1, 1, 9, 1'b1, a); drain(9);
    issue(1'b0, 3'b010, 32'h1000, '0,            32'h0, 1'b1, 1, 10, 1'b1, a); drain(10);
    issue(1'b0, 3'b011, 32'h14,   '0,            32'h0, 1'b1, 1, 11, 1'b1, a); drain(11);
    issue(1'b1, 3'b100, 32'h08,   32'h0000_0055, 32'h0, 1'b1, 1, 12, 1'b1, a); drain(12);
    chk("err_no_write", we_cnt - wc, 0);
    chk("err_mem2", mem[2], 32'hAABB_11DD);
    chk("err_mem0", mem[0], 32'h0);

    // Reset during the read phase of a half store
    wc = we_cnt;
    issue(1'b1, 3'b001, 32'h0A, 32'h0000_BEEF, 32'h0, 1'b0, 3, 13, 1'b0, a);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_midrst", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_no_write", we_cnt - wc, 0);
    chk("midrst_mem2", mem[2], 32'hAABB_11DD);

    // Back-to-back with req_valid held high
    issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 14, 1'b1, a);
    issue(1'b0, 3'b010, 32'h20, '0, 32'hDEAD_BEEF, 1'b0, 2, 15, 1'b1, a2);
    drain(15);
    chk("b2b_accept_gap", a2 - a, 3);
    chk("b2b_mem8", mem[8], 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
